traceback_unit: RTL and testbench
=================================

Name: traceback_unit

Overview:
Reader side of the survivor memory. On each Start pulse it walks the 256-state trellis backwards through the 2048x8 survivor RAM, one trellis stage per two clocks, beginning at a given stage and state. It emits one chronologically ordered decoded byte per traceback. It sits between the ACS/survivor-write path and the decoder output, and drives the RAM read port (RAMEnable active-low, RWSelect=1).

Parameters:
WD_STATE, 8, state width (256 states, K=9)
WD_STAGE, 6, trellis stage index width (64 stages held in RAM)
WD_RAM_ADDRESS, 11, RAM address width = WD_STAGE + WD_STATE - 3
WD_RAM_DATA, 8, RAM word width; 8 survivor bits per word
TB_LENGTH, 64, stages traced per run, including the decode stages
DECODE_LEN, 8, final stages whose bits are output; must equal WD_RAM_DATA

Ports:
Clock  input  1  single clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request; accepted only when Busy=0
StartStage  input  WD_STAGE  newest stage to trace from
StartState  input  WD_STATE  best-metric state at StartStage
RAMEnable  output  1  survivor RAM enable, active-low
RWSelect  output  1  held at 1 (read) in all states
AddressRAM  output  WD_RAM_ADDRESS  {stage, state[7:3]}
DataRAM  input  WD_RAM_DATA  RAM read data, valid in the cycle after address issue
Busy  output  1  traceback in progress
DecodedByte  output  DECODE_LEN  decoded bits; bit0 = oldest
DecodedValid  output  1  one-cycle strobe qualifying DecodedByte

Behaviour:
- Reset (sync, high) values: RAMEnable=1, RWSelect=1, AddressRAM=0, Busy=0, DecodedByte=0, DecodedValid=0. FSM goes to IDLE, counters clear.
- FSM states: IDLE, ISSUE, UPDATE.
- IDLE: if Start=1, latch cur_stage=StartStage, cur_state=StartState, k=0, and go to ISSUE. Busy rises in the next cycle.
- ISSUE: RAMEnable=0, AddressRAM={cur_stage, cur_state[7:3]}. Go to UPDATE.
- UPDATE: RAMEnable=0, address held. Sample surv=DataRAM[cur_state[2:0]] and dec=cur_state[WD_STATE-1], then:
  - cur_state <= {cur_state[WD_STATE-2:0], surv}
  - cur_stage <= cur_stage-1, modulo 2^WD_STAGE (0 wraps to 63)
  - if k >= TB_LENGTH-DECODE_LEN: shreg <= {shreg[6:0], dec}
  - if k == TB_LENGTH-1: go to IDLE, DecodedByte <= final shreg, DecodedValid <= 1, Busy <= 0
  - otherwise: k <= k+1 and go to ISSUE
- Outside ISSUE/UPDATE, RAMEnable=1.
- Timing: Start sampled at edge t gives ISSUE for k=0 in cycle t+1. The run takes 2*TB_LENGTH cycles. Busy is high in cycles t+1..t+128. DecodedValid is high only in cycle t+129, and DecodedByte holds that value until the next run completes.
- A new Start may be accepted in the cycle DecodedValid is high (FSM is in IDLE).
- Start while Busy=1 is ignored; the run in progress is unaffected.
- Reset asserted mid-run aborts immediately: reset values apply, no DecodedValid is produced, and the partial shreg is discarded.
- The counter k is log2(TB_LENGTH) bits wide; all stage arithmetic is unsigned modulo 2^WD_STAGE.

Decomposition:
- Width constants go in the shared params.v: `WD_RAM_ADDRESS, `WD_RAM_DATA, `WD_FSM-style stage width, and new `WD_STATE, `TB_LENGTH, `DECODE_LEN.
- One sub-module is natural: survivor_bit_select, an 8:1 mux from DataRAM to surv indexed by state[2:0]. The FSM, counters and shift register stay in the top module.

Test Plan:
- RAM all 0x00, StartStage=10, StartState=0x00 -> 64 reads at addresses 320, 288, ... (stage decrementing, state 0). DecodedValid exactly 129 cycles after Start, DecodedByte=0x00.
- RAM all 0xFF, StartState=0x00 -> state fills with 1s and reaches 0xFF by k=8, so DecodedByte=0xFF. Busy high for exactly 128 cycles.
- StartStage=5, StartState=0xA5 -> first AddressRAM=0x0B4 with RAMEnable=0 and bit 5 selected. Check the second address matches the predicted {4, next_state[7:3]}.
- StartStage=0 -> the second issued address uses stage 63 (wrap-around). Each later stage decrements modulo 64.
- Start re-pulsed at cycles t+20 and t+128 -> both ignored, a single DecodedValid. A Start in the DecodedValid cycle starts a new run, with Busy high in the next cycle.
- Reset pulsed at cycle t+50 -> in the next cycle Busy=0, RAMEnable=1, AddressRAM=0, and no DecodedValid follows. A subsequent Start then completes normally.

Source files
------------

// File: rtl/traceback_unit_pkg.sv
// Shared widths, FSM state type and address helper for the survivor-memory
// traceback reader.
package traceback_unit_pkg;

    // Trellis geometry: 256 states (K=9), 64 stages resident in the RAM.
    localparam int WD_STATE       = 8;
    localparam int WD_STAGE       = 6;
    // One RAM word holds the survivor bits of 8 neighbouring states, so the
    // low three state bits select a bit inside the word, not a word.
    localparam int WD_RAM_DATA    = 8;
    localparam int WD_SEL         = $clog2(WD_RAM_DATA);
    localparam int WD_RAM_ADDRESS = WD_STAGE + WD_STATE - WD_SEL;

    // Stages walked per run; only the oldest DECODE_LEN of them are emitted.
    // DECODE_LEN must equal WD_RAM_DATA so a run yields exactly one byte.
    localparam int TB_LENGTH      = 64;
    localparam int DECODE_LEN     = 8;
    localparam int WD_COUNT       = $clog2(TB_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_UPDATE
    } tbState_t;

    // RAM word address for a given stage/state pair: {stage, state[7:3]}.
    function automatic logic [WD_RAM_ADDRESS-1:0] makeAddress(
        input logic [WD_STAGE-1:0] stage,
        input logic [WD_STATE-1:0] state
    );
        return {stage, state[WD_STATE-1:WD_SEL]};
    endfunction

endpackage

// File: rtl/traceback_unit_survivor_bit_select.sv
// Picks the survivor bit of one state out of an 8-state RAM word.
module survivor_bit_select
    import traceback_unit_pkg::*;
(
    input  logic [WD_RAM_DATA-1:0] i_data,
    input  logic [WD_SEL-1:0]      i_select,
    output logic                   o_bit
);

    // Plain 8:1 mux indexed by the low state bits.
    always_comb begin
        o_bit = i_data[i_select];
    end

endmodule

// File: rtl/traceback_unit.sv
// Traceback reader: walks the trellis backwards through the survivor RAM,
// one stage per two clocks (address issue, then data update), and emits the
// oldest decoded bits of each run as one chronologically ordered byte.
module traceback_unit
    import traceback_unit_pkg::*;
(
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [WD_STAGE-1:0]       StartStage,
    input  logic [WD_STATE-1:0]       StartState,
    output logic                      RAMEnable,
    output logic                      RWSelect,
    output logic [WD_RAM_ADDRESS-1:0] AddressRAM,
    input  logic [WD_RAM_DATA-1:0]    DataRAM,
    output logic                      Busy,
    output logic [DECODE_LEN-1:0]     DecodedByte,
    output logic                      DecodedValid
);

    localparam logic [WD_COUNT-1:0] DECODE_START = WD_COUNT'(TB_LENGTH - DECODE_LEN);
    localparam logic [WD_COUNT-1:0] LAST_STEP    = WD_COUNT'(TB_LENGTH - 1);

    tbState_t                  r_state;
    logic [WD_STAGE-1:0]       r_curStage;
    logic [WD_STATE-1:0]       r_curState;
    logic [WD_COUNT-1:0]       r_count;
    logic [DECODE_LEN-1:0]     r_shreg;
    logic                      r_ramEnable;
    logic [WD_RAM_ADDRESS-1:0] r_address;
    logic                      r_busy;
    logic [DECODE_LEN-1:0]     r_decodedByte;
    logic                      r_decodedValid;

    logic                      w_survivor;
    logic                      w_decodedBit;
    logic [WD_STATE-1:0]       w_nextState;
    logic [WD_STAGE-1:0]       w_prevStage;
    logic [DECODE_LEN-1:0]     w_nextShreg;

    survivor_bit_select u_bitSelect (
        .i_data   (DataRAM),
        .i_select (r_curState[WD_SEL-1:0]),
        .o_bit    (w_survivor)
    );

    // One backward step: the decoded bit is the state's MSB, the predecessor
    // state shifts the survivor bit in at the bottom, and the stage index
    // wraps modulo the RAM depth.
    always_comb begin
        w_decodedBit = r_curState[WD_STATE-1];
        w_nextState  = {r_curState[WD_STATE-2:0], w_survivor};
        w_prevStage  = r_curStage - WD_STAGE'(1);
        w_nextShreg  = {r_shreg[DECODE_LEN-2:0], w_decodedBit};
    end

    // Control FSM with registered RAM-port and result outputs; the next RAM
    // address is computed during UPDATE so it is on the port in ISSUE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state        <= ST_IDLE;
            r_curStage     <= '0;
            r_curState     <= '0;
            r_count        <= '0;
            r_shreg        <= '0;
            r_ramEnable    <= 1'b1;
            r_address      <= '0;
            r_busy         <= 1'b0;
            r_decodedByte  <= '0;
            r_decodedValid <= 1'b0;
        end else begin
            r_decodedValid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_curStage  <= StartStage;
                        r_curState  <= StartState;
                        r_count     <= '0;
                        r_shreg     <= '0;
                        r_address   <= makeAddress(StartStage, StartState);
                        r_ramEnable <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    r_curState <= w_nextState;
                    r_curStage <= w_prevStage;
                    if (r_count >= DECODE_START) begin
                        r_shreg <= w_nextShreg;
                    end
                    if (r_count == LAST_STEP) begin
                        r_decodedByte  <= w_nextShreg;
                        r_decodedValid <= 1'b1;
                        r_busy         <= 1'b0;
                        r_ramEnable    <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else begin
                        r_count   <= r_count + WD_COUNT'(1);
                        r_address <= makeAddress(w_prevStage, w_nextState);
                        r_state   <= ST_ISSUE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ramEnable <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign RAMEnable    = r_ramEnable;
    assign RWSelect     = 1'b1;
    assign AddressRAM   = r_address;
    assign Busy         = r_busy;
    assign DecodedByte  = r_decodedByte;
    assign DecodedValid = r_decodedValid;

endmodule

// File: tb/tb_traceback_unit.sv
// Self-checking bench for traceback_unit: a registered survivor RAM model,
// a stage/state walk model computed with plain arithmetic, and directed plus
// randomized traceback runs.
module tb_traceback_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start;
    logic [5:0]  StartStage;
    logic [7:0]  StartState;
    logic        RAMEnable;
    logic        RWSelect;
    logic [10:0] AddressRAM;
    logic [7:0]  DataRAM;
    logic        Busy;
    logic [7:0]  DecodedByte;
    logic        DecodedValid;

    logic [7:0]  mem [0:2047];

    int          checks   = 0;
    int          failures = 0;

    int          expAddr [0:63];
    int          expByte;
    int          firstAddr;
    int          secondAddr;

    traceback_unit dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .StartStage   (StartStage),
        .StartState   (StartState),
        .RAMEnable    (RAMEnable),
        .RWSelect     (RWSelect),
        .AddressRAM   (AddressRAM),
        .DataRAM      (DataRAM),
        .Busy         (Busy),
        .DecodedByte  (DecodedByte),
        .DecodedValid (DecodedValid)
    );

    // 10 ns clock.
    always #5 Clock = ~Clock;

    // Synchronous survivor RAM: data appears the cycle after the address.
    always @(posedge Clock) begin
        if (RAMEnable === 1'b0) begin
            DataRAM <= mem[AddressRAM];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Walk the trellis backwards with integer arithmetic: address is
    // stage*32 + state/8, survivor bit is bit (state mod 8) of that word,
    // the decoded bit is the state's top bit, and the previous state is
    // (2*state + survivor) mod 256. The last 8 decoded bits form the byte.
    task automatic computeModel(input int stage, input int state);
        int s, g, b, surv, dec;
        s = state;
        g = stage;
        b = 0;
        for (int k = 0; k < 64; k++) begin
            expAddr[k] = g * 32 + s / 8;
            surv = (int'(mem[expAddr[k]]) >> (s % 8)) & 1;
            dec  = s / 128;
            s    = (s * 2 + surv) % 256;
            g    = (g + 63) % 64;
            if (k >= 56) b = (b * 2 + dec) % 256;
        end
        expByte = b;
    endtask

    task automatic applyStimulus(input int stage, input int state);
        Start      = 1'b1;
        StartStage = 6'(stage);
        StartState = 8'(state);
    endtask

    task automatic fillMem(input int mode);
        for (int i = 0; i < 2048; i++) begin
            mem[i] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
        end
    endtask

    // Starts a run in the current cycle and follows it to the DecodedValid
    // cycle, leaving the bench at the negedge of that cycle.
    task automatic runAndCheck(input int stage, input int state, input bit rePulse, input string name);
        int busyCount, validCount, validAt, enErr, busyFirst;
        busyCount  = 0;
        validCount = 0;
        validAt    = 0;
        enErr      = 0;
        busyFirst  = 0;
        computeModel(stage, state);
        applyStimulus(stage, state);
        for (int c = 1; c <= 129; c++) begin
            @(negedge Clock);
            Start = (rePulse && (c == 20 || c == 128)) ? 1'b1 : 1'b0;
            if (c == 1) begin
                busyFirst = int'(Busy);
                firstAddr = int'(AddressRAM);
            end
            if (c == 3) secondAddr = int'(AddressRAM);
            if ((c % 2) == 1 && c <= 127) begin
                checkOutput({name, "_addr"}, 32'(AddressRAM), 32'(expAddr[(c - 1) / 2]));
            end
            if (c <= 128 && RAMEnable !== 1'b0) enErr++;
            if (Busy === 1'b1) busyCount++;
            if (DecodedValid === 1'b1) begin
                validCount++;
                validAt = c;
            end
        end
        Start = 1'b0;
        checkOutput({name, "_busyFirst"}, 32'(busyFirst), 32'd1);
        checkOutput({name, "_ramEnLowCycles"}, 32'(enErr), 32'd0);
        checkOutput({name, "_ramEnDone"}, 32'(RAMEnable), 32'd1);
        checkOutput({name, "_rwSelect"}, 32'(RWSelect), 32'd1);
        checkOutput({name, "_busyCycles"}, 32'(busyCount), 32'd128);
        checkOutput({name, "_busyDone"}, 32'(Busy), 32'd0);
        checkOutput({name, "_validCount"}, 32'(validCount), 32'd1);
        checkOutput({name, "_validCycle"}, 32'(validAt), 32'd129);
        checkOutput({name, "_byte"}, 32'(DecodedByte), 32'(expByte));
    endtask

    task automatic idleCheck(input int n, input string name);
        int v;
        v = 0;
        repeat (n) begin
            @(negedge Clock);
            if (DecodedValid === 1'b1) v++;
        end
        checkOutput({name, "_noValid"}, 32'(v), 32'd0);
    endtask

    initial begin
        int held;
        Reset      = 1'b1;
        Start      = 1'b0;
        StartStage = '0;
        StartState = '0;
        DataRAM    = '0;
        fillMem(0);
        repeat (3) @(negedge Clock);
        checkOutput("rst_ramEn", 32'(RAMEnable), 32'd1);
        checkOutput("rst_rwSel", 32'(RWSelect), 32'd1);
        checkOutput("rst_addr", 32'(AddressRAM), 32'd0);
        checkOutput("rst_busy", 32'(Busy), 32'd0);
        checkOutput("rst_byte", 32'(DecodedByte), 32'd0);
        checkOutput("rst_valid", 32'(DecodedValid), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);

        $display("[TB] all-zero RAM, stage 10, state 0x00");
        runAndCheck(10, 0, 1'b0, "zeros");
        checkOutput("zeros_firstAddr", 32'(firstAddr), 32'd320);
        checkOutput("zeros_secondAddr", 32'(secondAddr), 32'd288);
        checkOutput("zeros_byteConst", 32'(DecodedByte), 32'h00);
        idleCheck(4, "afterZeros");

        $display("[TB] all-ones RAM, state 0x00");
        fillMem(1);
        runAndCheck(20, 0, 1'b0, "ones");
        checkOutput("ones_byteConst", 32'(DecodedByte), 32'hFF);
        idleCheck(4, "afterOnes");

        $display("[TB] random RAM, stage 5, state 0xA5");
        fillMem(2);
        runAndCheck(5, 8'hA5, 1'b0, "a5");
        checkOutput("a5_firstAddr", 32'(firstAddr), 32'h0B4);
        checkOutput("a5_secondStage", 32'(secondAddr / 32), 32'd4);
        idleCheck(3, "afterA5");

        $display("[TB] stage 0 wrap-around");
        runAndCheck(0, int'($urandom_range(255)), 1'b0, "wrap");
        checkOutput("wrap_secondStage", 32'(secondAddr / 32), 32'd63);
        idleCheck(3, "afterWrap");

        $display("[TB] Start re-pulsed while busy");
        fillMem(2);
        runAndCheck(int'($urandom_range(63)), int'($urandom_range(255)), 1'b1, "repulse");
        held = expByte;
        idleCheck(140, "afterRepulse");
        checkOutput("repulse_byteHeld", 32'(DecodedByte), 32'(held));

        $display("[TB] back-to-back runs, Start in DecodedValid cycle");
        runAndCheck(int'($urandom_range(63)), int'($urandom_range(255)), 1'b0, "chainA");
        runAndCheck(int'($urandom_range(63)), int'($urandom_range(255)), 1'b0, "chainB");
        idleCheck(3, "afterChain");

        $display("[TB] reset mid-run");
        held = int'(DecodedByte);
        applyStimulus(int'($urandom_range(63)), int'($urandom_range(255)));
        for (int c = 1; c <= 50; c++) begin
            @(negedge Clock);
            Start = 1'b0;
        end
        checkOutput("midrun_busyBefore", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(negedge Clock);
        checkOutput("abort_busy", 32'(Busy), 32'd0);
        checkOutput("abort_ramEn", 32'(RAMEnable), 32'd1);
        checkOutput("abort_addr", 32'(AddressRAM), 32'd0);
        checkOutput("abort_byte", 32'(DecodedByte), 32'd0);
        checkOutput("abort_valid", 32'(DecodedValid), 32'd0);
        Reset = 1'b0;
        idleCheck(150, "afterAbort");
        runAndCheck(int'($urandom_range(63)), int'($urandom_range(255)), 1'b0, "postReset");
        idleCheck(2, "afterPostReset");

        $display("[TB] randomized runs");
        for (int r = 0; r < 4; r++) begin
            fillMem(2);
            runAndCheck(int'($urandom_range(63)), int'($urandom_range(255)), 1'b0, "random");
            idleCheck(int'($urandom_range(5, 1)), "afterRandom");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
